// File: rtl/prog_loader.sv
// Streams a program image (address, length, data[, checksum]) into RAM and then releases the CPU
// from reset. Define CHECKSUM_EN to add the trailing checksum byte and the ERR state.
module prog_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLen,
    StData,
    StDone
`ifdef CHECKSUM_EN
    ,
    StCsum,
    StErr
`endif
  } state_e;

  // Count is one bit wider so a length byte of 0 can mean a full 2^ADDR_W transfer.
  localparam logic [ADDR_W:0] CntOne = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CntMax = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                xfer;
  logic [ADDR_W-1:0]   in_addr;

  assign xfer    = in_valid & in_ready;
  assign in_addr = ADDR_W'(in_data);

`ifdef CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] in_byte;
  logic [7:0] sum_chk;

  assign in_byte = 8'(in_data);
  assign sum_chk = sum_q + in_byte;

  always_comb begin
    sum_d = sum_q;
    if (state_q == StIdle || state_q == StDone || state_q == StErr) begin
      sum_d = '0;
    end else if (xfer && state_q != StCsum) begin
      sum_d = sum_chk;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StAddr;
      StAddr:         if (xfer) state_d = StLen;
      StLen:          if (xfer) state_d = StData;
      StData: begin
        if (xfer && cnt_q == CntOne) begin
`ifdef CHECKSUM_EN
          state_d = StCsum;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef CHECKSUM_EN
      StCsum:         if (xfer) state_d = (sum_chk == 8'd0) ? StDone : StErr;
      StErr:          if (start) state_d = StAddr;
`endif
      default:        state_d = StIdle;
    endcase
  end

  // Datapath next-state: pointer, count and the one-cycle-delayed RAM write.
  always_comb begin
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (xfer && state_q == StAddr) begin
      ptr_d = in_addr;
    end
    if (xfer && state_q == StLen) begin
      cnt_d = (in_addr == '0) ? CntMax : {1'b0, in_addr};
    end
    if (xfer && state_q == StData) begin
      mem_we_d   = 1'b1;
      mem_addr_d = ptr_q;
      mem_data_d = in_data;
      ptr_d      = ptr_q + ADDR_W'(1);
      cnt_d      = cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      cnt_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_rst_n = 1'b0;
    unique case (state_q)
      StAddr, StLen, StData: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      StDone: begin
        done      = 1'b1;
        cpu_rst_n = 1'b1;
      end
`ifdef CHECKSUM_EN
      StCsum: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      StErr:   err = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes are queued at byte acceptance and
// matched (address, data, exact cycle) by a monitor. Honours CHECKSUM_EN like the RTL.
module tb_prog_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       cpu_rst_n;
  logic       busy;
  logic       done;
  logic       err;

  prog_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    longint     t;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] dq[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_wr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every mem_we must match the oldest queued write, one cycle after acceptance.
  always @(negedge clk) begin : mon
    wr_t e;
    if (mem_we === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(mem_addr), 32'(e.addr));
        check_eq("wr_data", 32'(mem_data), 32'(e.data));
        check_eq("wr_time", 32'($time), 32'(e.t));
      end
    end
  end

  // Offer one byte (after an idle gap) and wait for acceptance; called and returns at a negedge.
  task automatic send(input logic [7:0] b, input bit wr, input logic [7:0] a, input int gap);
    int  n = 0;
    wr_t e;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      check_eq("ready_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      if (wr) begin
        e.addr = a;
        e.data = b;
        e.t    = longint'($time) + 5;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Full load of dq; stops after n_send data bytes when n_send < dq.size().
  task automatic load(input logic [7:0] a, input logic [7:0] l, input bit bad, input bit gaps,
                      input int n_send);
    logic [7:0] sum;
    logic [7:0] wa;
    int         n = 0;
    sum      = a + l;
    wa       = a;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = a;
    check_eq("ready_on_start", 32'(in_ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    send(a, 1'b0, 8'h00, 0);
    send(l, 1'b0, 8'h00, 0);
    for (int i = 0; i < dq.size(); i++) begin
      if (i >= n_send) return;
      send(dq[i], 1'b1, wa, gaps ? int'($urandom_range(0, 2)) : 0);
      sum = sum + dq[i];
      wa  = wa + 8'd1;
    end
`ifdef CHECKSUM_EN
    send(bad ? 8'h00 : 8'h00 - sum, 1'b0, 8'h00, 0);
`else
    if (bad) check_eq("bad_csum_unsupported", 32'd0, 32'd1);
`endif
    while (done !== 1'b1 && err !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, "_mem_data"}, 32'(mem_data), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("idle_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      check_eq("idle_in_ready", 32'(in_ready), 32'd0);
    end
    check_eq("idle_no_writes", 32'(n_wr), 32'd0);

    // Basic load at address 0
    dq = '{8'h00, 8'h52, 8'h82};
    load(8'h00, 8'h03, 1'b0, 1'b0, 3);
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check_eq("t1_err", 32'(err), 32'd0);
    check_eq("t1_in_ready", 32'(in_ready), 32'd0);

    // Address wrap
    dq = '{8'hA1, 8'hA2, 8'hA3};
    load(8'hFE, 8'h03, 1'b0, 1'b0, 3);
    check_eq("t2_done", 32'(done), 32'd1);
    check_eq("t2_busy", 32'(busy), 32'd0);

`ifdef CHECKSUM_EN
    dq = '{8'h00, 8'h52, 8'h82};
    load(8'h00, 8'h03, 1'b1, 1'b0, 3);
    check_eq("t3_err", 32'(err), 32'd1);
    check_eq("t3_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check_eq("t3_done", 32'(done), 32'd0);
    load(8'h00, 8'h03, 1'b0, 1'b0, 3);
    check_eq("t3_retry_done", 32'(done), 32'd1);
    check_eq("t3_retry_err", 32'(err), 32'd0);
`endif

    // Full 256-byte load with random valid gaps
    dq = {};
    for (int i = 0; i < 256; i++) dq.push_back(8'($urandom_range(0, 255)));
    w0 = n_wr;
    load(8'h37, 8'h00, 1'b0, 1'b1, 256);
    check_eq("t4_write_count", 32'(n_wr - w0), 32'd256);
    check_eq("t4_queue_empty", 32'(exp_q.size()), 32'd0);
    check_eq("t4_done", 32'(done), 32'd1);

    // Reset after two data bytes of a five-byte load
    dq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    w0 = n_wr;
    load(8'h10, 8'h05, 1'b0, 1'b0, 2);
    in_valid = 1'b1;
    in_data  = 8'h33;
    rst      = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst      = 1'b0;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check_eq("midrst_write_count", 32'(n_wr - w0), 32'd2);
    check_eq("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
    check_eq("midrst_idle_ready", 32'(in_ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
